// File: rtl/calc_pkg.sv
// Shared calculator definitions: token codes, splitter FSM states and default sizes.
package calc_pkg;

  localparam logic [3:0] TOK_ADD = 4'hA;
  localparam logic [3:0] TOK_SUB = 4'hB;
  localparam logic [3:0] TOK_MUL = 4'hC;
  localparam logic [3:0] TOK_DIV = 4'hD;
  localparam logic [3:0] TOK_EQ  = 4'hE;
  localparam logic [3:0] TOK_CLR = 4'hF;

  localparam int unsigned SPLIT_WIDTH  = 32;
  localparam int unsigned SPLIT_DIGITS = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SIGN    = 2'd2,
    EMIT    = 2'd3
  } split_state_e;

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble step: per-nibble +3 adjust (no inter-nibble carry), then shift {bcd, bin} left by one.
module bin2bcd_step #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic [WIDTH-1:0]    bin_i,
  output logic [4*DIGITS-1:0] bcd_c,
  output logic [WIDTH-1:0]    bin_c
);

  logic [4*DIGITS-1:0] adj_c;

  always_comb begin
    adj_c = bcd_i;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
    end
    bcd_c = {adj_c[4*DIGITS-2:0], bin_i[WIDTH-1]};
    bin_c = {bin_i[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/number_splitter.sv
// Binary result to MSD-first decimal token stream with leading-zero suppression.
// Define DIGIT_SIGN_EN to treat Number as two's complement and prefix negatives with TOK_SUB.
module number_splitter
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = SPLIT_WIDTH,
  parameter int unsigned DIGITS = SPLIT_DIGITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Number,
  input  logic             load,
  output logic             splitter_ready,
  output logic [3:0]       Token,
  output logic             token_strobe,
  input  logic             token_ready,
  output logic             last
);

  localparam int unsigned BCDW = 4 * DIGITS;
  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  split_state_e     state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCDW-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       token_q, token_d;
  logic             strobe_q, strobe_d;
  logic             last_q, last_d;
  logic             ready_q, ready_d;
`ifdef DIGIT_SIGN_EN
  logic             neg_q, neg_d;
`endif

  logic [BCDW-1:0]  bcd_step_c;
  logic [WIDTH-1:0] bin_step_c;
  logic [WIDTH-1:0] mag_c;
  logic [IW-1:0]    msd_idx_c, idx_prev_c;
  logic [3:0]       msd_nib_c, prev_nib_c;
  logic             xfer_c;

  assign splitter_ready = ready_q;
  assign Token          = token_q;
  assign token_strobe   = strobe_q;
  assign last           = last_q;
  assign xfer_c         = strobe_q && token_ready;
  assign idx_prev_c     = idx_q - IW'(1);

`ifdef DIGIT_SIGN_EN
  assign mag_c = Number[WIDTH-1] ? (~Number + WIDTH'(1)) : Number;
`else
  assign mag_c = Number;
`endif

  bin2bcd_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step (
    .bcd_i (bcd_q),
    .bin_i (bin_q),
    .bcd_c (bcd_step_c),
    .bin_c (bin_step_c)
  );

  // Most significant nonzero nibble (0 for a zero value) and the nibble below the current index.
  always_comb begin
    msd_idx_c  = '0;
    msd_nib_c  = '0;
    prev_nib_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        msd_idx_c = IW'(i);
        msd_nib_c = bcd_q[4*i +: 4];
      end
      if (IW'(i) == idx_prev_c) prev_nib_c = bcd_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      token_q  <= '0;
      strobe_q <= 1'b0;
      last_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef DIGIT_SIGN_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      token_q  <= token_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
`ifdef DIGIT_SIGN_EN
      neg_q    <= neg_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: begin
        if (cnt_q == CW'(1)) begin
`ifdef DIGIT_SIGN_EN
          state_d = neg_q ? SIGN : EMIT;
`else
          state_d = EMIT;
`endif
        end
      end
`ifdef DIGIT_SIGN_EN
      SIGN:    if (xfer_c) state_d = EMIT;
`endif
      EMIT:    if (xfer_c && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; an unstrobed SIGN/EMIT cycle is the entry cycle.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    token_d  = token_q;
    strobe_d = strobe_q;
    last_d   = last_q;
    ready_d  = ready_q;
`ifdef DIGIT_SIGN_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (load) begin
          bin_d   = mag_c;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          ready_d = 1'b0;
`ifdef DIGIT_SIGN_EN
          neg_d   = Number[WIDTH-1];
`endif
        end
      end
      CONVERT: begin
        bcd_d = bcd_step_c;
        bin_d = bin_step_c;
        cnt_d = cnt_q - CW'(1);
      end
`ifdef DIGIT_SIGN_EN
      SIGN: begin
        if (!strobe_q) begin
          token_d  = TOK_SUB;
          strobe_d = 1'b1;
          last_d   = 1'b0;
        end else if (token_ready) begin
          idx_d   = msd_idx_c;
          token_d = msd_nib_c;
          last_d  = (msd_idx_c == '0);
        end
      end
`endif
      EMIT: begin
        if (!strobe_q) begin
          idx_d    = msd_idx_c;
          token_d  = msd_nib_c;
          strobe_d = 1'b1;
          last_d   = (msd_idx_c == '0);
        end else if (token_ready) begin
          if (last_q) begin
            token_d  = '0;
            strobe_d = 1'b0;
            last_d   = 1'b0;
            ready_d  = 1'b1;
          end else begin
            idx_d   = idx_prev_c;
            token_d = prev_nib_c;
            last_d  = (idx_prev_c == '0);
          end
        end
      end
      default: ;
    endcase
  end

endmodule
